inv_permutation_func: RTL and testbench
=======================================

Name: inv_permutation_func

Overview:
- Inverse of the 64-slice, 25-bit state permutation engine. Streams in 64 permuted slices, applies the inverse pi lane mapping to each, and streams out the restored slices.
- Sits on the decode/readback path. It consumes exactly the line sequence the forward permutation block writes, in the same order and with the same bit layout.
- Fixed-latency, handshake-throttled FSM with a single slice register and a line counter.

Parameters:
- W, 25, slice width in bits (5x5 plane); only 25 is supported.
- LINES, 64, slices per frame.
- CNT_W, 6, line counter width; must satisfy 2^CNT_W >= LINES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- in_valid  input  1  line_in holds a valid slice.
- line_in  input  W  permuted slice, bit index i = 5*y + x.
- in_ready  output  1  block accepts line_in this cycle.
- out_ready  input  1  downstream accepts write_value.
- write_enable  output  1  write_value/cnt_value valid (out_valid).
- write_value  output  W  restored slice.
- cnt_value  output  CNT_W  index of the current slice (0..LINES-1).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last slice is accepted downstream.

Behaviour:
- Reset: state=IDLE, slice_reg=0, cnt=0. in_ready, write_enable, busy and done are 0; write_value=0; cnt_value=0.
- Mapping: out(x,y) = in(y, (2x+3y) mod 5), with x,y in 0..4 and index 5*y+x. This is the exact inverse of forward out(x,y) = in((x+3y) mod 5, x). The mapping is pure wiring.
- States: IDLE, LOAD, PERM, WRITE, DONE.
- IDLE: all strobes low. When start=1, go to LOAD with cnt=0.
- LOAD: in_ready=1. When in_valid=1, slice_reg<=line_in and go to PERM. Otherwise stay in LOAD.
- PERM: slice_reg<=invpi(slice_reg); go to WRITE. Always exactly 1 cycle.
- WRITE: write_enable=1, write_value=slice_reg, cnt_value=cnt. When out_ready=1 on the handshake edge:
  - if cnt==LINES-1, go to DONE;
  - otherwise cnt<=cnt+1 and go to LOAD.
- WRITE with out_ready=0: outputs are held stable; no change.
- DONE: done=1 for one cycle, cnt<=0, go to IDLE.
- Per-slice latency with in_valid=out_ready=1 is 3 cycles: LOAD, PERM, WRITE.
- Frame timing: start is sampled at edge E0. The last write handshake occurs at E(3*LINES). done is high in the cycle after that edge, i.e. between E192 and E193 for LINES=64.
- write_value equals slice_reg at all times. It shows the raw line during PERM; consumers qualify it with write_enable only.
- start is ignored while busy. start held high continuously launches back-to-back frames, with one IDLE cycle between frames.
- in_valid outside LOAD is ignored; no data is captured.
- Counter wrap: cnt never exceeds LINES-1. It returns to 0 only via DONE or rst.
- Reset mid-frame: immediate return to IDLE, cnt=0, slice_reg=0. The partial frame is discarded and done is not pulsed.
- Simultaneous rst and start: rst wins.

Test Plan:
- Single bit, LINES=64: start=1 for 1 cycle; all slices 25'h0000400 (bit 10); in_valid=out_ready=1.
  - Each write_value = 25'h0000002 (bit 1); cnt_value steps 0..63.
  - done is high exactly 1 cycle, between E192 and E193.
- Bit mapping checks:
  - line_in = bit 16 -> write_value = bit 5.
  - line_in = bit 0 -> write_value = bit 0.
  - line_in = 25'h1FFFFFF -> write_value = 25'h1FFFFFF.
- Round trip: 64 random slices through the forward-permutation model, then through this block -> write_value matches the originals in order, cnt_value 0..63.
- Backpressure:
  - out_ready=0 for 5 cycles on slice 7 -> write_enable, write_value and cnt_value=7 held stable.
  - in_valid gapped for 3 cycles -> block stays in LOAD with in_ready=1 and no capture.
  - Total frame length grows by exactly 8 cycles.
- Reset mid-frame: assert rst at slice 30 -> next cycle busy=0, cnt_value=0, write_value=0, no done pulse. A new start then runs a clean 64-slice frame.
- Start during busy: pulse start at slices 10 and 63 -> no restart, cnt sequence unbroken, a single done pulse.

Source files
------------

// File: rtl/inv_permutation_func.sv
// Inverse pi lane permutation over a stream of 64 slices of 25 bits.
// One slice is held at a time: load it, permute it in place, then write it out under handshake.
module inv_permutation_func #(
    parameter int W     = 25,
    parameter int LINES = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     line_in,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             write_enable,
    output logic [W-1:0]     write_value,
    output logic [CNT_W-1:0] cnt_value,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PERM  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINES - 1);

    logic [2:0]       state;
    logic [W-1:0]     slice_reg;
    logic [W-1:0]     slice_pi;
    logic [CNT_W-1:0] cnt;

    // out(x,y) = in(y, (2x+3y) mod 5), bit index 5*y + x; undoes the forward pi.
    for (genvar y = 0; y < 5; y++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_col
            assign slice_pi[5*y + x] = slice_reg[5*((2*x + 3*y) % 5) + y];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            slice_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        slice_reg <= line_in;
                        state     <= S_PERM;
                    end
                end
                S_PERM: begin
                    slice_reg <= slice_pi;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // write_value mirrors slice_reg continuously; only write_enable qualifies it.
    assign in_ready     = (state == S_LOAD);
    assign write_enable = (state == S_WRITE);
    assign write_value  = slice_reg;
    assign cnt_value    = cnt;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

endmodule

// File: tb/tb_inv_permutation_func.sv
// Self-checking bench for inv_permutation_func: frame-level scoreboard plus timing checks.
module tb_inv_permutation_func;

    localparam int W     = 25;
    localparam int LINES = 64;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [W-1:0]     line_in;
    logic             in_ready;
    logic             out_ready;
    logic             write_enable;
    logic [W-1:0]     write_value;
    logic [CNT_W-1:0] cnt_value;
    logic             busy;
    logic             done;

    inv_permutation_func #(.W(W), .LINES(LINES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .line_in(line_in),
        .in_ready(in_ready), .out_ready(out_ready), .write_enable(write_enable),
        .write_value(write_value), .cnt_value(cnt_value), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]     val;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    exp_t         exp_q[$];
    logic [W-1:0] in_data[LINES];
    logic [W-1:0] exp_data[LINES];
    vec_t         tab[6];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int src_idx = 0;
    int src_n = 0;
    int gap_at = -1;
    int gap_left = 0;
    int stall_at = -1;
    int stall_left = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int recv = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Forward pi: out(x,y) = in((x+3y) mod 5, x).
    function automatic logic [W-1:0] fwd_pi(input logic [W-1:0] s);
        logic [W-1:0] o;
        o = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                o[5*y + x] = s[5*x + ((x + 3*y) % 5)];
        return o;
    endfunction

    // Input side: present slices, optionally starve the block while it waits in LOAD.
    initial begin
        logic hs;
        in_valid = 1'b0;
        line_in  = '0;
        forever begin
            @(negedge clk);
            hs = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (hs) begin
                exp_q.push_back('{val: exp_data[src_idx], cnt: CNT_W'(src_idx)});
                src_idx++;
            end
            if (in_ready && src_idx == gap_at && gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else if (src_idx < src_n) begin
                in_valid = 1'b1;
                line_in  = in_data[src_idx];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Output side: stall the chosen slice for a number of cycles.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (write_enable && int'(cnt_value) == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard side: compare on each write handshake, and hold values during stalls.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (write_enable && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(write_value), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_value", 32'(write_value), 32'(e.val));
                    chk("cnt_value", 32'(cnt_value), 32'(e.cnt));
                    recv++;
                end
            end else if (write_enable && !out_ready && exp_q.size() > 0) begin
                chk("stall_value_hold", 32'(write_value), 32'(exp_q[0].val));
                chk("stall_cnt_hold", 32'(cnt_value), 32'(exp_q[0].cnt));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk);
        #2;
        recv      = 0;
        src_idx   = 0;
        src_n     = LINES;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int extra);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 600) begin
            @(posedge clk);
            #3;
            k++;
        end
        if (done_cnt == d0) begin
            chk({name, "_done_timeout"}, 32'(k), 32'(0));
        end else begin
            chk({name, "_done_cycle"}, 32'(done_cyc), 32'(start_cyc + 3*LINES + 1 + extra));
            @(negedge clk);
            #1;
            chk({name, "_done_one_cycle"}, 32'(done), 32'(0));
            chk({name, "_slices"}, 32'(recv), 32'(LINES));
            chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
            chk({name, "_idle"}, 32'(busy), 32'(0));
        end
    endtask

    task automatic fill_round_trip();
        logic [W-1:0] orig;
        for (int i = 0; i < LINES; i++) begin
            orig        = W'($urandom) & 25'h1FF_FFFF;
            exp_data[i] = orig;
            in_data[i]  = fwd_pi(orig);
        end
    endtask

    task automatic wait_write_cnt(input int n);
        int k;
        k = 0;
        while (!(write_enable && int'(cnt_value) == n) && k < 400) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("wait_write_cnt_timeout", 32'(k < 400), 32'(1));
    endtask

    task automatic wait_load_cnt(input int n);
        int k;
        k = 0;
        while (!(in_ready && int'(cnt_value) == n) && k < 400) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("wait_load_cnt_timeout", 32'(k < 400), 32'(1));
    endtask

    initial begin
        int d0;
        tab[0] = '{din: 25'h000_0400, dout: 25'h000_0002};
        tab[1] = '{din: 25'h001_0000, dout: 25'h000_0020};
        tab[2] = '{din: 25'h000_0001, dout: 25'h000_0001};
        tab[3] = '{din: 25'h1FF_FFFF, dout: 25'h1FF_FFFF};
        tab[4] = '{din: 25'h100_0000, dout: 25'h020_0000};
        tab[5] = '{din: 25'h000_0002, dout: 25'h000_0040};

        rst   = 1'b1;
        start = 1'b1;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_write_enable", 32'(write_enable), 32'(0));
        chk("rst_write_value", 32'(write_value), 32'(0));
        chk("rst_cnt_value", 32'(cnt_value), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        repeat (2) @(posedge clk);
        #3;
        chk("rst_beats_start", 32'(busy), 32'(0));
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single-bit frame: bit 10 maps to bit 1.
        for (int i = 0; i < LINES; i++) begin
            in_data[i]  = 25'h000_0400;
            exp_data[i] = 25'h000_0002;
        end
        start_frame();
        wait_done("single_bit", 0);

        // Table-driven mapping vectors cycled through one frame.
        for (int i = 0; i < LINES; i++) begin
            in_data[i]  = tab[i % 6].din;
            exp_data[i] = tab[i % 6].dout;
        end
        start_frame();
        wait_done("table", 0);

        fill_round_trip();
        start_frame();
        wait_done("round_trip", 0);

        // Input gap of 3 at slice 20 and output stall of 5 at slice 7.
        fill_round_trip();
        gap_at     = 20;
        gap_left   = 3;
        stall_at   = 7;
        stall_left = 5;
        start_frame();
        wait_done("backpressure", 8);
        chk("gap_consumed", 32'(gap_left), 32'(0));
        chk("stall_consumed", 32'(stall_left), 32'(0));
        gap_at   = -1;
        stall_at = -1;

        // Reset in the middle of slice 30.
        fill_round_trip();
        d0 = done_cnt;
        start_frame();
        wait_write_cnt(30);
        rst   = 1'b1;
        src_n = 0;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_cnt", 32'(cnt_value), 32'(0));
        chk("midrst_value", 32'(write_value), 32'(0));
        chk("midrst_write_enable", 32'(write_enable), 32'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        exp_q.delete();
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        fill_round_trip();
        start_frame();
        wait_done("after_reset", 0);

        // Start pulses while busy must not restart the frame.
        fill_round_trip();
        d0 = done_cnt;
        start_frame();
        wait_load_cnt(10);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_load_cnt(63);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("start_busy", 0);
        repeat (10) @(posedge clk);
        #2;
        chk("start_busy_single_done", 32'(done_cnt), 32'(d0 + 1));
        chk("start_busy_no_restart", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
